// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a split addr_ok/data_ok bus and holds the result for WB.
// Optional `MEM_LOAD_ALIGN_EN: extract and extend the load lane here instead of in WB.
module mem_access_stage #(
    parameter int SIDE_W    = 64,
    parameter int FIXED_MAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              exe_valid_in,
    output logic              mem_allowin_out,
    input  logic              exe_mem_en_in,
    input  logic              exe_mem_wr_in,
    input  logic [1:0]        exe_size_in,
    input  logic              exe_load_sign_in,
    input  logic [31:0]       exe_vaddr_in,
    input  logic [31:0]       exe_wdata_in,
    input  logic [3:0]        exe_wstrb_in,
    input  logic [31:0]       exe_result_in,
    input  logic [SIDE_W-1:0] exe_side_in,
    input  logic              wb_allowin_in,
    output logic              mem_valid_out,
    output logic [31:0]       mem_wbdata_out,
    output logic [SIDE_W-1:0] mem_side_out,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

    state_t            state_p1, state_d;
    logic              wr_p1;
    logic [1:0]        size_p1;
    logic [31:0]       addr_p1;
    logic [3:0]        wstrb_p1;
    logic [31:0]       wdata_p1;
    logic [31:0]       result_p1;
    logic [SIDE_W-1:0] side_p1;
    logic              vld_p1;
    logic              capture;
    logic              complete;
    logic [31:0]       load_data;

    // kseg0/kseg1 strip the top three bits; everything else passes through
    function automatic logic [31:0] translate(input logic [31:0] va);
        if (FIXED_MAP != 0 && (va[31:29] == 3'b100 || va[31:29] == 3'b101))
            return {3'b000, va[28:0]};
        return va;
    endfunction

`ifdef MEM_LOAD_ALIGN_EN
    logic load_sign_p1;

    function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] a, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    return {{24{sgn & b[7]}}, b};
            2'd1:    return {{16{sgn & h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    assign load_data = align_load(data_rdata, size_p1, addr_p1[1:0], load_sign_p1);
`else
    wire unused_load_sign = exe_load_sign_in;
    assign load_data = data_rdata;
`endif

    assign vld_p1          = (state_p1 == S_DONE);
    assign mem_allowin_out = (state_p1 == S_IDLE) || (vld_p1 && wb_allowin_in);
    assign capture         = mem_allowin_out && exe_valid_in && !flush;
    assign complete        = (state_d == S_DONE) && (state_p1 == S_REQ || state_p1 == S_WAIT);

    always_comb begin
        state_d = state_p1;
        case (state_p1)
            S_IDLE:
                if (capture) state_d = exe_mem_en_in ? S_REQ : S_DONE;
            S_REQ:
                if (data_addr_ok) begin
                    if (data_data_ok) state_d = flush ? S_IDLE : S_DONE;
                    else              state_d = flush ? S_CANCEL : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            S_WAIT:
                if (data_data_ok) state_d = flush ? S_IDLE : S_DONE;
                else if (flush)   state_d = S_CANCEL;
            S_DONE:
                if (capture)                     state_d = exe_mem_en_in ? S_REQ : S_DONE;
                else if (flush || wb_allowin_in) state_d = S_IDLE;
            S_CANCEL:
                if (data_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // p1: instruction held in MEM; request fields stay frozen until the next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1     <= S_IDLE;
            wr_p1        <= 1'b0;
            size_p1      <= 2'd0;
            addr_p1      <= 32'd0;
            wstrb_p1     <= 4'd0;
            wdata_p1     <= 32'd0;
            result_p1    <= 32'd0;
            side_p1      <= '0;
`ifdef MEM_LOAD_ALIGN_EN
            load_sign_p1 <= 1'b0;
`endif
        end else begin
            state_p1 <= state_d;
            if (capture) begin
                wr_p1        <= exe_mem_wr_in;
                size_p1      <= exe_size_in;
                addr_p1      <= translate(exe_vaddr_in);
                wstrb_p1     <= exe_wstrb_in;
                wdata_p1     <= exe_wdata_in;
                result_p1    <= exe_result_in;
                side_p1      <= exe_side_in;
`ifdef MEM_LOAD_ALIGN_EN
                load_sign_p1 <= exe_load_sign_in;
`endif
            end else if (complete && !wr_p1) begin
                result_p1 <= load_data;
            end
        end
    end

    assign mem_valid_out  = vld_p1;
    assign mem_wbdata_out = result_p1;
    assign mem_side_out   = side_p1;
    assign data_req       = (state_p1 == S_REQ);
    assign data_wr        = wr_p1;
    assign data_size      = size_p1;
    assign data_addr      = addr_p1;
    assign data_wstrb     = wstrb_p1;
    assign data_wdata     = wdata_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed vectors push expected WB results, a monitor pops them.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        exe_valid_in;
    logic        mem_allowin_out;
    logic        exe_mem_en_in;
    logic        exe_mem_wr_in;
    logic [1:0]  exe_size_in;
    logic        exe_load_sign_in;
    logic [31:0] exe_vaddr_in;
    logic [31:0] exe_wdata_in;
    logic [3:0]  exe_wstrb_in;
    logic [31:0] exe_result_in;
    logic [63:0] exe_side_in;
    logic        wb_allowin_in;
    logic        mem_valid_out;
    logic [31:0] mem_wbdata_out;
    logic [63:0] mem_side_out;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    mem_access_stage #(.SIDE_W(64), .FIXED_MAP(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .exe_valid_in(exe_valid_in), .mem_allowin_out(mem_allowin_out),
        .exe_mem_en_in(exe_mem_en_in), .exe_mem_wr_in(exe_mem_wr_in),
        .exe_size_in(exe_size_in), .exe_load_sign_in(exe_load_sign_in),
        .exe_vaddr_in(exe_vaddr_in), .exe_wdata_in(exe_wdata_in),
        .exe_wstrb_in(exe_wstrb_in), .exe_result_in(exe_result_in),
        .exe_side_in(exe_side_in), .wb_allowin_in(wb_allowin_in),
        .mem_valid_out(mem_valid_out), .mem_wbdata_out(mem_wbdata_out),
        .mem_side_out(mem_side_out), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

`ifdef MEM_LOAD_ALIGN_EN
    localparam logic [31:0] EXP_LB = 32'hFFFF_FF80;
    localparam logic [31:0] EXP_LH = 32'h0000_8001;
`else
    localparam logic [31:0] EXP_LB = 32'h80FF_FF00;
    localparam logic [31:0] EXP_LH = 32'h8001_1234;
`endif

    typedef struct {
        logic [31:0] data;
        logic [63:0] side;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exe_valid_in     = 1'b0;
        exe_mem_en_in    = 1'b0;
        exe_mem_wr_in    = 1'b0;
        exe_size_in      = 2'd0;
        exe_load_sign_in = 1'b0;
        exe_vaddr_in     = 32'd0;
        exe_wdata_in     = 32'd0;
        exe_wstrb_in     = 4'd0;
        exe_result_in    = 32'd0;
        exe_side_in      = 64'd0;
    endtask

    task automatic drive(input logic en, input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] va, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [31:0] res, input logic [63:0] side);
        exe_valid_in     = 1'b1;
        exe_mem_en_in    = en;
        exe_mem_wr_in    = wr;
        exe_size_in      = size;
        exe_load_sign_in = sgn;
        exe_vaddr_in     = va;
        exe_wdata_in     = wd;
        exe_wstrb_in     = ws;
        exe_result_in    = res;
        exe_side_in      = side;
    endtask

    task automatic push(input logic [31:0] d, input logic [63:0] s);
        exp_t e;
        e.data = d;
        e.side = s;
        sb.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"},   64'(mem_valid_out),   64'd0);
        check({tag, "_allowin"}, 64'(mem_allowin_out), 64'd1);
        check({tag, "_req"},     64'(data_req),        64'd0);
        check({tag, "_wbdata"},  64'(mem_wbdata_out),  64'd0);
        check({tag, "_side"},    mem_side_out,         64'd0);
        check({tag, "_addr"},    64'(data_addr),       64'd0);
        check({tag, "_wr"},      64'(data_wr),         64'd0);
        check({tag, "_wstrb"},   64'(data_wstrb),      64'd0);
        check({tag, "_wdata"},   64'(data_wdata),      64'd0);
    endtask

    // Monitor: every WB handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (mem_valid_out === 1'b1 && wb_allowin_in === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_wb: got data %0h side %0h, expected no output", mem_wbdata_out, mem_side_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_data", 64'(mem_wbdata_out), 64'(e.data));
                check("wb_side", mem_side_out, e.side);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        wb_allowin_in = 1'b1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = 32'd0;
        idle_inputs();
        tick();
        tick();
        check_reset("rst0");
        rst = 1'b0;
        tick();

        // Non-memory op: valid for exactly one cycle after capture
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234, 64'h11);
        push(32'h1234, 64'h11);
        tick();
        idle_inputs();
        check("nonmem_valid", 64'(mem_valid_out), 64'd1);
        check("nonmem_data", 64'(mem_wbdata_out), 64'h1234);
        tick();
        check("nonmem_valid_drop", 64'(mem_valid_out), 64'd0);

        // lb signed from kseg0 with addr_ok delayed two cycles
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 4'h0, 32'hDEAD, 64'hAB);
        push(EXP_LB, 64'hAB);
        tick();
        idle_inputs();
        exe_vaddr_in = 32'hFFFF_FFFF;
        check("lb_req", 64'(data_req), 64'd1);
        check("lb_addr", 64'(data_addr), 64'h3);
        check("lb_allowin", 64'(mem_allowin_out), 64'd0);
        tick();
        tick();
        check("lb_req_held", 64'(data_req), 64'd1);
        check("lb_addr_held", 64'(data_addr), 64'h3);
        check("lb_size_held", 64'(data_size), 64'd0);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("lb_wait_req", 64'(data_req), 64'd0);
        check("lb_wait_valid", 64'(mem_valid_out), 64'd0);
        data_data_ok = 1'b1;
        data_rdata = 32'h80FF_FF00;
        tick();
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        check("lb_valid", 64'(mem_valid_out), 64'd1);
        tick();
        check("lb_idle", 64'(mem_valid_out), 64'd0);

        // lhu from kseg0 with addr_ok and data_ok together: valid at N+2
        drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h9FFF_FFFE, 32'h0, 4'h0, 32'h0, 64'h5A);
        push(EXP_LH, 64'h5A);
        tick();
        idle_inputs();
        check("lh_addr", 64'(data_addr), 64'h1FFF_FFFE);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'h8001_1234;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        check("lh_valid", 64'(mem_valid_out), 64'd1);
        tick();

        // Store through kseg1 while WB stalls for three cycles
        wb_allowin_in = 1'b0;
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'hA000_1000, 32'h1122_3344, 4'hF, 32'h55, 64'h77);
        push(32'h55, 64'h77);
        tick();
        idle_inputs();
        check("st_addr", 64'(data_addr), 64'h1000);
        check("st_wr", 64'(data_wr), 64'd1);
        check("st_wdata", 64'(data_wdata), 64'h1122_3344);
        check("st_wstrb", 64'(data_wstrb), 64'hF);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'hCAFE_F00D;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("st_stall_valid", 64'(mem_valid_out), 64'd1);
            check("st_stall_allowin", 64'(mem_allowin_out), 64'd0);
            check("st_stall_data", 64'(mem_wbdata_out), 64'h55);
            tick();
        end
        wb_allowin_in = 1'b1;
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0, 32'h99, 64'h88);
        push(32'h99, 64'h88);
        #1;
        check("st_release_allowin", 64'(mem_allowin_out), 64'd1);
        tick();
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0, 32'hAA, 64'h89);
        push(32'hAA, 64'h89);
        check("b2b_valid0", 64'(mem_valid_out), 64'd1);
        check("b2b_data0", 64'(mem_wbdata_out), 64'h99);
        tick();
        idle_inputs();
        check("b2b_valid1", 64'(mem_valid_out), 64'd1);
        check("b2b_data1", 64'(mem_wbdata_out), 64'hAA);
        tick();
        check("b2b_idle", 64'(mem_valid_out), 64'd0);

        // Flush in WAIT: drain to IDLE, stale rdata discarded
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0F0F, 64'h21);
        tick();
        idle_inputs();
        check("fw_addr", 64'(data_addr), 64'h100);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fw_cancel_allowin", 64'(mem_allowin_out), 64'd0);
        check("fw_cancel_valid", 64'(mem_valid_out), 64'd0);
        check("fw_cancel_req", 64'(data_req), 64'd0);
        tick();
        check("fw_cancel_hold", 64'(mem_allowin_out), 64'd0);
        data_data_ok = 1'b1;
        data_rdata = 32'hBADB_AD00;
        tick();
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        check("fw_idle_allowin", 64'(mem_allowin_out), 64'd1);
        check("fw_idle_valid", 64'(mem_valid_out), 64'd0);
        check("fw_no_stale", 64'(mem_wbdata_out), 64'h0F0F);

        // Flush in REQ without addr_ok, then flush blocks capture
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'hC000_0010, 32'h0, 4'h0, 32'h0, 64'h31);
        tick();
        check("fr_req", 64'(data_req), 64'd1);
        check("fr_addr_kseg2", 64'(data_addr), 64'hC000_0010);
        flush = 1'b1;
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0, 32'h4444, 64'h32);
        tick();
        check("fr_req_drop", 64'(data_req), 64'd0);
        check("fr_allowin", 64'(mem_allowin_out), 64'd1);
        tick();
        flush = 1'b0;
        idle_inputs();
        check("fr_no_capture_valid", 64'(mem_valid_out), 64'd0);
        check("fr_no_capture_req", 64'(data_req), 64'd0);
        tick();
        check("fr_still_empty", 64'(mem_valid_out), 64'd0);

        // Reset while waiting for data_ok
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_2000, 32'h0, 4'h0, 32'h777, 64'h3C);
        tick();
        idle_inputs();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("rw_wait_side", mem_side_out, 64'h3C);
        rst = 1'b1;
        tick();
        check_reset("rst_wait");
        rst = 1'b0;
        tick();
        check("rw_after_valid", 64'(mem_valid_out), 64'd0);

        tick();
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
